// File: rtl/aq_fcnvt_narrow_dnml_sh_if.sv
// Operation/result bundle for the narrowing-convert denormal alignment shifter.
// The master drives operations and accepts results; the slave is the shifter.
interface aq_fcnvt_narrow_dnml_sh_if #(
  parameter int TAG_W = 4,
  parameter int DST_W = 23
);
  logic             src_vld;
  logic             src_rdy;
  logic [1:0]       src_mode;
  logic [10:0]      src_exp;
  logic [51:0]      src_frac;
  logic [TAG_W-1:0] src_tag;
  logic             dst_vld;
  logic             dst_rdy;
  logic [DST_W-1:0] dst_frac;
  logic             dst_grd;
  logic             dst_stk;
  logic             dst_not_dnml;
  logic [TAG_W-1:0] dst_tag;

  modport master (
    output src_vld, src_mode, src_exp, src_frac, src_tag, dst_rdy,
    input  src_rdy, dst_vld, dst_frac, dst_grd, dst_stk, dst_not_dnml, dst_tag
  );

  modport slave (
    input  src_vld, src_mode, src_exp, src_frac, src_tag, dst_rdy,
    output src_rdy, dst_vld, dst_frac, dst_grd, dst_stk, dst_not_dnml, dst_tag
  );
endinterface

// File: rtl/aq_fcnvt_narrow_dnml_sh.sv
// Two-stage denormal alignment shifter for D->S, D->H and S->H conversions.
// Stage 1 computes the clamped shift; stage 2 shifts and produces guard/sticky.
module aq_fcnvt_narrow_dnml_sh #(
  parameter int TAG_W = 4,
  parameter int DST_W = 23
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst,
  input  logic                          pipe_flush,
  aq_fcnvt_narrow_dnml_sh_if.slave      bus
);

  logic [11:0]      emin_s;
  logic [11:0]      exp_ext_s;
  logic [11:0]      sh_s;
  logic [4:0]       clamp_s;
  logic [4:0]       sh_clamp_s;
  logic [52:0]      sig_s;
  logic             mode_ok_s;
  logic             not_dnml_s;
  logic             s2_can_load_s;
  logic             src_rdy_s;

  logic             s1_vld_r;
  logic [1:0]       s1_mode_r;
  logic [4:0]       s1_sh_r;
  logic             s1_not_dnml_r;
  logic [52:0]      s1_sig_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic [4:0]       sh_amt_s;
  logic [77:0]      aligned_s;
  logic [DST_W-1:0] frac_s;
  logic             grd_s;
  logic             stk_s;

  logic             dst_vld_r;
  logic [DST_W-1:0] dst_frac_r;
  logic             dst_grd_r;
  logic             dst_stk_r;
  logic             dst_not_dnml_r;
  logic [TAG_W-1:0] dst_tag_r;

  assign s2_can_load_s = !dst_vld_r || bus.dst_rdy;
  assign src_rdy_s     = !s1_vld_r || s2_can_load_s;

  // Stage 1: per-format minimum exponent, shift distance and clamp.
  always_comb begin
    emin_s    = 12'd0;
    clamp_s   = 5'd0;
    mode_ok_s = 1'b1;
    exp_ext_s = {1'b0, bus.src_exp};
    sig_s     = {1'b1, bus.src_frac};
    case (bus.src_mode)
      2'b00: begin
        emin_s  = 12'd897;
        clamp_s = 5'd26;
      end
      2'b01: begin
        emin_s  = 12'd1009;
        clamp_s = 5'd13;
      end
      2'b10: begin
        emin_s    = 12'd113;
        clamp_s   = 5'd13;
        exp_ext_s = {4'd0, bus.src_exp[7:0]};
        sig_s     = {1'b1, bus.src_frac[51:29], 29'd0};
      end
      default: begin
        mode_ok_s = 1'b0;
      end
    endcase
    sh_s       = emin_s - exp_ext_s;
    not_dnml_s = !mode_ok_s || sh_s[11] || (sh_s == 12'd0);
    if (not_dnml_s) begin
      sh_clamp_s = 5'd0;
    end else if (sh_s > {7'd0, clamp_s}) begin
      sh_clamp_s = clamp_s;
    end else begin
      sh_clamp_s = sh_s[4:0];
    end
  end

  // Stage 1 register: accepts a new op whenever the stage can move on.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      s1_vld_r      <= 1'b0;
      s1_mode_r     <= 2'b00;
      s1_sh_r       <= 5'd0;
      s1_not_dnml_r <= 1'b0;
      s1_sig_r      <= 53'd0;
      s1_tag_r      <= '0;
    end else if (pipe_flush) begin
      s1_vld_r <= 1'b0;
    end else if (src_rdy_s) begin
      s1_vld_r <= bus.src_vld;
      if (bus.src_vld) begin
        s1_mode_r     <= bus.src_mode;
        s1_sh_r       <= sh_clamp_s;
        s1_not_dnml_r <= not_dnml_s;
        s1_sig_r      <= sig_s;
        s1_tag_r      <= bus.src_tag;
      end
    end
  end

  // Stage 2: the hidden one lands at aligned_s[77] (weight 2^-1) when sh=1.
  always_comb begin
    sh_amt_s  = s1_sh_r - 5'd1;
    aligned_s = {s1_sig_r, 25'd0} >> sh_amt_s;
    frac_s    = '0;
    grd_s     = 1'b0;
    stk_s     = 1'b0;
    if (s1_not_dnml_r) begin
      frac_s = '0;
    end else begin
      case (s1_mode_r)
        2'b00: begin
          frac_s = aligned_s[77:55];
          grd_s  = aligned_s[54];
          stk_s  = |aligned_s[53:0];
        end
        2'b01, 2'b10: begin
          frac_s = {{(DST_W-10){1'b0}}, aligned_s[77:68]};
          grd_s  = aligned_s[67];
          stk_s  = |aligned_s[66:0];
        end
        default: begin
          frac_s = '0;
        end
      endcase
    end
  end

  // Stage 2 register: output holds while a result waits for dst_rdy.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      dst_vld_r      <= 1'b0;
      dst_frac_r     <= '0;
      dst_grd_r      <= 1'b0;
      dst_stk_r      <= 1'b0;
      dst_not_dnml_r <= 1'b0;
      dst_tag_r      <= '0;
    end else if (pipe_flush) begin
      dst_vld_r <= 1'b0;
    end else if (s2_can_load_s) begin
      dst_vld_r <= s1_vld_r;
      if (s1_vld_r) begin
        dst_frac_r     <= frac_s;
        dst_grd_r      <= grd_s;
        dst_stk_r      <= stk_s;
        dst_not_dnml_r <= s1_not_dnml_r;
        dst_tag_r      <= s1_tag_r;
      end
    end
  end

  assign bus.src_rdy      = src_rdy_s;
  assign bus.dst_vld      = dst_vld_r;
  assign bus.dst_frac     = dst_frac_r;
  assign bus.dst_grd      = dst_grd_r;
  assign bus.dst_stk      = dst_stk_r;
  assign bus.dst_not_dnml = dst_not_dnml_r;
  assign bus.dst_tag      = dst_tag_r;

endmodule

// File: tb/tb_aq_fcnvt_narrow_dnml_sh.sv
// Directed bench for the denormal alignment shifter: conversions, stalls,
// back-to-back issue, flush and asynchronous reset.
module tb_aq_fcnvt_narrow_dnml_sh;

  logic forever_cpuclk;
  logic cpurst;
  logic pipe_flush;
  int   total;
  int   bad;

  aq_fcnvt_narrow_dnml_sh_if #(.TAG_W(4), .DST_W(23)) bus ();

  aq_fcnvt_narrow_dnml_sh #(.TAG_W(4), .DST_W(23)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .pipe_flush     (pipe_flush),
    .bus            (bus)
  );

  initial begin
    forever_cpuclk = 1'b0;
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  typedef struct packed {
    logic [1:0]  mode;
    logic [10:0] exp;
    logic [51:0] frac;
    logic [3:0]  tag;
    logic [22:0] e_frac;
    logic        e_grd;
    logic        e_stk;
    logic        e_nd;
  } vec_t;

  task automatic drive(input logic vld, input logic [1:0] mode, input logic [10:0] exp,
                       input logic [51:0] frac, input logic [3:0] tag);
    bus.src_vld  = vld;
    bus.src_mode = mode;
    bus.src_exp  = exp;
    bus.src_frac = frac;
    bus.src_tag  = tag;
  endtask

  task automatic test_reset();
    cpurst     = 1'b1;
    pipe_flush = 1'b0;
    bus.dst_rdy = 1'b1;
    drive(1'b0, 2'b00, 11'd0, 52'd0, 4'd0);
    repeat (2) @(negedge forever_cpuclk);
    total++;
    if ({bus.dst_vld, bus.dst_frac, bus.dst_grd, bus.dst_stk, bus.dst_not_dnml, bus.dst_tag} !== 31'd0) begin
      bad++;
      $display("FAIL reset_outputs: got vld=%b frac=%h grd=%b stk=%b nd=%b tag=%h want all 0",
               bus.dst_vld, bus.dst_frac, bus.dst_grd, bus.dst_stk, bus.dst_not_dnml, bus.dst_tag);
    end
    cpurst = 1'b0;
    #1;
    total++;
    if (bus.src_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_src_rdy: got %b want 1", bus.src_rdy);
    end
  endtask

  task automatic test_convert();
    vec_t vecs[13];
    int   lat;
    vecs[0]  = '{2'b00, 11'd896,  52'd0,               4'd3, 23'h400000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 11'd873,  52'h8000000000000,   4'd4, 23'h000000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 11'd850,  52'd0,               4'd5, 23'h000000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 11'd1008, 52'd0,               4'd6, 23'h000200, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 11'd1009, 52'd0,               4'd7, 23'h000000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'b11, 11'd500,  52'h123,             4'd8, 23'h000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b10, 11'd100,  52'd0,               4'd9, 23'h000000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'b10, 11'd112,  {23'h400000, 29'd0}, 4'hA, 23'h000300, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 11'd890,  52'hF000000000001,   4'hB, 23'h01F000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 11'h770,  52'h000001FFFFFFF,   4'hC, 23'h000200, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 11'd998,  52'd1,               4'hD, 23'h000000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 11'd872,  52'd0,               4'hE, 23'h000000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{2'b00, 11'd1500, 52'hFFFFFFFFFFFFF,   4'hF, 23'h000000, 1'b0, 1'b0, 1'b1};
    bus.dst_rdy = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge forever_cpuclk);
      drive(1'b1, vecs[i].mode, vecs[i].exp, vecs[i].frac, vecs[i].tag);
      @(negedge forever_cpuclk);
      bus.src_vld = 1'b0;
      lat = 1;
      while (!bus.dst_vld && lat < 10) begin
        @(negedge forever_cpuclk);
        lat++;
      end
      total++;
      if (lat != 2) begin
        bad++;
        $display("FAIL convert_latency[%0d]: got %0d cycles want 2", i, lat);
      end
      total++;
      if ({bus.dst_frac, bus.dst_grd, bus.dst_stk, bus.dst_not_dnml, bus.dst_tag} !==
          {vecs[i].e_frac, vecs[i].e_grd, vecs[i].e_stk, vecs[i].e_nd, vecs[i].tag}) begin
        bad++;
        $display("FAIL convert[%0d]: got frac=%h grd=%b stk=%b nd=%b tag=%h want frac=%h grd=%b stk=%b nd=%b tag=%h",
                 i, bus.dst_frac, bus.dst_grd, bus.dst_stk, bus.dst_not_dnml, bus.dst_tag,
                 vecs[i].e_frac, vecs[i].e_grd, vecs[i].e_stk, vecs[i].e_nd, vecs[i].tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.dst_rdy = 1'b1;
    @(negedge forever_cpuclk);
    drive(1'b1, 2'b00, 11'd896, 52'd0, 4'd1);
    @(negedge forever_cpuclk);
    drive(1'b1, 2'b10, 11'd112, {23'h400000, 29'd0}, 4'd2);
    @(negedge forever_cpuclk);
    bus.src_vld = 1'b0;
    total++;
    if (bus.dst_vld !== 1'b1 || bus.dst_tag !== 4'd1 || bus.dst_frac !== 23'h400000) begin
      bad++;
      $display("FAIL b2b_first: got vld=%b tag=%h frac=%h want vld=1 tag=1 frac=400000",
               bus.dst_vld, bus.dst_tag, bus.dst_frac);
    end
    @(negedge forever_cpuclk);
    total++;
    if (bus.dst_vld !== 1'b1 || bus.dst_tag !== 4'd2 || bus.dst_frac !== 23'h000300) begin
      bad++;
      $display("FAIL b2b_second: got vld=%b tag=%h frac=%h want vld=1 tag=2 frac=000300",
               bus.dst_vld, bus.dst_tag, bus.dst_frac);
    end
    @(negedge forever_cpuclk);
    total++;
    if (bus.dst_vld !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drained: got vld=%b want 0", bus.dst_vld);
    end
  endtask

  task automatic test_stall();
    int          sent;
    int          rcv;
    logic [22:0] e_frac;
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge forever_cpuclk);
      bus.dst_rdy = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
      drive(sent < 4, 2'b01, 11'(1008 - sent), 52'd0, 4'(sent));
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        total++;
        if (bus.src_rdy !== 1'b0) begin
          bad++;
          $display("FAIL stall_src_rdy cyc%0d: got %b want 0", cyc, bus.src_rdy);
        end
        total++;
        if (bus.dst_vld !== 1'b1 || bus.dst_tag !== 4'd0 || bus.dst_frac !== 23'h000200) begin
          bad++;
          $display("FAIL stall_hold cyc%0d: got vld=%b tag=%h frac=%h want vld=1 tag=0 frac=000200",
                   cyc, bus.dst_vld, bus.dst_tag, bus.dst_frac);
        end
      end
      if (bus.dst_vld && bus.dst_rdy) begin
        e_frac = 23'h000200 >> rcv;
        total++;
        if (bus.dst_tag !== 4'(rcv) || bus.dst_frac !== e_frac) begin
          bad++;
          $display("FAIL stall_order #%0d: got tag=%h frac=%h want tag=%h frac=%h",
                   rcv, bus.dst_tag, bus.dst_frac, 4'(rcv), e_frac);
        end
        rcv++;
      end
      if (bus.src_vld && bus.src_rdy) sent++;
    end
    bus.src_vld = 1'b0;
    total++;
    if (rcv != 4 || sent != 4) begin
      bad++;
      $display("FAIL stall_count: got sent=%0d received=%0d want 4 and 4", sent, rcv);
    end
  endtask

  task automatic test_flush();
    bus.dst_rdy = 1'b0;
    @(negedge forever_cpuclk);
    drive(1'b1, 2'b00, 11'd896, 52'd0, 4'd6);
    @(negedge forever_cpuclk);
    drive(1'b1, 2'b00, 11'd896, 52'd0, 4'd7);
    pipe_flush = 1'b1;
    @(negedge forever_cpuclk);
    pipe_flush  = 1'b0;
    bus.src_vld = 1'b0;
    bus.dst_rdy = 1'b1;
    #1;
    total++;
    if (bus.dst_vld !== 1'b0 || bus.src_rdy !== 1'b1) begin
      bad++;
      $display("FAIL flush_next: got dst_vld=%b src_rdy=%b want 0 and 1", bus.dst_vld, bus.src_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge forever_cpuclk);
      total++;
      if (bus.dst_vld !== 1'b0) begin
        bad++;
        $display("FAIL flush_stale %0d: got dst_vld=%b tag=%h want 0", i, bus.dst_vld, bus.dst_tag);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.dst_rdy = 1'b0;
    @(negedge forever_cpuclk);
    drive(1'b1, 2'b00, 11'd896, 52'd0, 4'd5);
    @(negedge forever_cpuclk);
    drive(1'b1, 2'b01, 11'd1008, 52'd0, 4'd6);
    @(negedge forever_cpuclk);
    bus.src_vld = 1'b0;
    total++;
    if (bus.dst_vld !== 1'b1 || bus.dst_tag !== 4'd5 || bus.dst_frac !== 23'h400000) begin
      bad++;
      $display("FAIL rst_pre: got vld=%b tag=%h frac=%h want vld=1 tag=5 frac=400000",
               bus.dst_vld, bus.dst_tag, bus.dst_frac);
    end
    #1 cpurst = 1'b1;
    #1;
    total++;
    if ({bus.dst_vld, bus.dst_frac, bus.dst_grd, bus.dst_stk, bus.dst_not_dnml, bus.dst_tag} !== 31'd0 ||
        bus.src_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rst_async: got vld=%b frac=%h tag=%h src_rdy=%b want all 0 and src_rdy=1",
               bus.dst_vld, bus.dst_frac, bus.dst_tag, bus.src_rdy);
    end
    @(negedge forever_cpuclk);
    cpurst      = 1'b0;
    bus.dst_rdy = 1'b1;
    #1;
    total++;
    if (bus.src_rdy !== 1'b1) begin
      bad++;
      $display("FAIL rst_release: got src_rdy=%b want 1", bus.src_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge forever_cpuclk);
      total++;
      if (bus.dst_vld !== 1'b0) begin
        bad++;
        $display("FAIL rst_stale %0d: got dst_vld=%b tag=%h want 0", i, bus.dst_vld, bus.dst_tag);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_convert();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aq_fcnvt_narrow_dnml_sh.md
# aq_fcnvt_narrow_dnml_sh

Pipelined, multi-format denormal alignment shifter for narrowing FP conversions: double→single, double→half and single→half. It takes a source exponent and fraction whose result underflows the destination format, right-shifts the significand (hidden one included) into the destination subnormal position, and produces the truncated fraction plus guard and sticky bits for the downstream rounder. It sits in the vfalu convert path between exponent classification and rounding. It has a two-stage valid/ready pipeline with flush and a pass-through tag.

## Interface
- TAG_W, 4, width of opaque tag carried alongside each operation
- DST_W, 23, output fraction width (max destination fraction, single)
- forever_cpuclk  input  1  clock
- cpurst  input  1  reset, asynchronous, active-high
- pipe_flush  input  1  kill all in-flight operations
- src_vld  input  1  operation valid
- src_rdy  output  1  block can accept operation this cycle
- src_mode  input  2  00 D→S, 01 D→H, 10 S→H, 11 reserved
- src_exp  input  11  biased source exponent (S source in [7:0], [10:8] ignored)
- src_frac  input  52  source fraction, left-aligned (S source in [51:29], [28:0] ignored/zero)
- src_tag  input  TAG_W  opaque tag
- dst_vld  output  1  result valid
- dst_rdy  input  1  downstream accepts result
- dst_frac  output  DST_W  destination subnormal fraction, right-aligned (half uses [9:0], [22:10]=0)
- dst_grd  output  1  first bit below dst LSB
- dst_stk  output  1  OR of all bits below guard
- dst_not_dnml  output  1  shift amount ≤0 or reserved mode; fraction/guard/sticky forced 0
- dst_tag  output  TAG_W  tag of the result

## Operation
- Per mode: EMIN = 897 (D→S), 1009 (D→H), 113 (S→H); F = 23, 10, 10.
- sh = EMIN − exp (12-bit signed). sh ≤ 0 or mode 11: dst_not_dnml=1, frac/grd/stk = 0.
- Significand sig = {1, src_frac} (53 bits); S source uses {1, src_frac[51:29]}.
- Result = sig shifted right by sh relative to destination binary point. dst_frac[F−1:0] = weights 2^-1..2^-F. dst_grd = weight 2^-(F+1). dst_stk = OR of all lower bits.
- Clamp sh to F+3 before shifting. For sh ≥ F+2: frac=0, grd=0, stk=1. sh = F+1: frac=0, grd=1, stk=|frac bits.
- Stage 1 registers mode, clamped sh, not_dnml, significand and tag. Stage 2 performs the barrel shift and sticky OR and registers the outputs.
- Handshake:
  - Stage 2 advances when !dst_vld or dst_rdy.
  - Stage 1 advances into stage 2 under the same condition.
  - src_rdy = !s1_vld | s2_can_load.
  - Transfer occurs on src_vld & src_rdy, or dst_vld & dst_rdy.
- Outputs hold stable while dst_vld & !dst_rdy.

## Timing
- Latency: 2 cycles from accepted input to dst_vld, with dst_rdy held high. Throughput: 1 op/cycle.
- src_rdy is combinational from dst_rdy and the stage valids; it has no path from src_vld.
- Reset: s1/s2 valids 0, dst_vld=0, dst_frac=0, dst_grd=0, dst_stk=0, dst_not_dnml=0, dst_tag=0. src_rdy=1 after reset deassertion.
- pipe_flush: both valids clear at the next edge. An input presented the same cycle is dropped. dst_vld=0 the following cycle.
- Reset asserted mid-operation: all in-flight ops are lost immediately (asynchronous). No output is produced for them.
- Full pipeline with dst_rdy=0: src_rdy=0. When dst_rdy rises, one result drains and src_rdy=1 in the same cycle. No bubble and no duplication.
- Ops leave in order. The tag always accompanies its own result.

## Test plan
- D→S, exp=896, frac=0, tag=3 → 2 cycles later: dst_frac=0x400000, grd=0, stk=0, not_dnml=0, tag=3.
- D→S, exp=873, frac=0x8000000000000 (bit51 only) → dst_frac=0, grd=1, stk=1. Then exp=850, frac=0 → frac=0, grd=0, stk=1.
- D→H, exp=1008, frac=0 → dst_frac=0x000200, grd=0, stk=0. D→H, exp=1009 → not_dnml=1, frac=0. Mode 11 with any input → not_dnml=1.
- S→H, exp=100 (sh=13) → frac=0, grd=0, stk=1. S→H, exp=112, frac[51:29]=0x400000 → dst_frac=0x300, grd=0, stk=0.
- Stream 4 ops (tags 0..3) with dst_rdy low for cycles 2–5 → src_rdy=0 while both stages are full. Results emerge tags 0,1,2,3 in order, each stable until its handshake, none lost or duplicated.
- Two ops in flight, pipe_flush pulsed → dst_vld=0 the next cycle, no stale results afterwards. Repeat with cpurst asserted mid-stream → all outputs 0 immediately, src_rdy=1 after release.
